// File: rtl/alu_pkg.sv
// Shared ALU encodings, ID/EX payload layout and forwarding helper for the
// issue stage.
package alu_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned FUNCT_W = 6;
   localparam int unsigned SIG_W   = 3;
   localparam int unsigned CNT_W   = 8;

   typedef enum logic [SIG_W-1:0] {
      SIG_AND = 3'b000,
      SIG_OR  = 3'b001,
      SIG_ADD = 3'b010,
      SIG_SRL = 3'b101,
      SIG_SUB = 3'b110,
      SIG_SLT = 3'b111
   } alu_sig_e;

   typedef enum logic [1:0] {
      ALUOP_MEM   = 2'b00,
      ALUOP_BR    = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_ILL   = 2'b11
   } aluop_e;

   localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
   localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
   localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
   localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
   localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;
   localparam logic [FUNCT_W-1:0] FUNCT_SRL = 6'b000010;

   typedef struct packed {
      logic             valid;
      logic [SIG_W-1:0] signal;
      logic [REG_W-1:0] shamt;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  rdata_a;
      logic [XLEN-1:0]  rdata_b;
      logic [XLEN-1:0]  imm;
      logic             alusrc;
      logic             regwrite;
      logic             illegal;
   } idex_t;

   // Youngest producer wins; register 0 is hardwired and never forwarded.
   function automatic logic [XLEN-1:0] fwd_sel(
      input logic [REG_W-1:0] src,
      input logic [XLEN-1:0]  rdata,
      input logic             exmem_we,
      input logic [REG_W-1:0] exmem_rd,
      input logic [XLEN-1:0]  exmem_res,
      input logic             memwb_we,
      input logic [REG_W-1:0] memwb_rd,
      input logic [XLEN-1:0]  memwb_res
   );
      if (src != '0 && exmem_we && exmem_rd == src) return exmem_res;
      if (src != '0 && memwb_we && memwb_rd == src) return memwb_res;
      return rdata;
   endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// ID-side inputs, forwarding sources and EX-side ALU outputs of the issue stage.
interface alu_issue_stage_if;
   import alu_pkg::*;

   logic               stall;
   logic               flush;
   logic               id_valid;
   logic [1:0]         id_aluop;
   logic [FUNCT_W-1:0] id_funct;
   logic [REG_W-1:0]   id_shamt;
   logic [REG_W-1:0]   id_rs;
   logic [REG_W-1:0]   id_rt;
   logic [REG_W-1:0]   id_rd;
   logic [XLEN-1:0]    id_rdataA;
   logic [XLEN-1:0]    id_rdataB;
   logic [XLEN-1:0]    id_imm;
   logic               id_alusrc;
   logic               id_regwrite;
   logic               exmem_regwrite;
   logic               memwb_regwrite;
   logic [REG_W-1:0]   exmem_rd;
   logic [REG_W-1:0]   memwb_rd;
   logic [XLEN-1:0]    exmem_result;
   logic [XLEN-1:0]    memwb_result;

   logic               ex_valid;
   logic [SIG_W-1:0]   ex_signal;
   logic [REG_W-1:0]   ex_shamt;
   logic [XLEN-1:0]    ex_dataA;
   logic [XLEN-1:0]    ex_dataB;
   logic [XLEN-1:0]    ex_storedata;
   logic [REG_W-1:0]   ex_rd;
   logic               ex_regwrite;
   logic               ex_illegal;
   logic [CNT_W-1:0]   illegal_cnt;

   modport master (
      output stall, flush, id_valid, id_aluop, id_funct, id_shamt, id_rs, id_rt, id_rd,
             id_rdataA, id_rdataB, id_imm, id_alusrc, id_regwrite,
             exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd, exmem_result, memwb_result,
      input  ex_valid, ex_signal, ex_shamt, ex_dataA, ex_dataB, ex_storedata,
             ex_rd, ex_regwrite, ex_illegal, illegal_cnt
   );

   modport slave (
      input  stall, flush, id_valid, id_aluop, id_funct, id_shamt, id_rs, id_rt, id_rd,
             id_rdataA, id_rdataB, id_imm, id_alusrc, id_regwrite,
             exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd, exmem_result, memwb_result,
      output ex_valid, ex_signal, ex_shamt, ex_dataA, ex_dataB, ex_storedata,
             ex_rd, ex_regwrite, ex_illegal, illegal_cnt
   );
endinterface

// File: rtl/alu_ctrl_dec.sv
// ALUOp/funct to ALU operation select; undecodable ops flag illegal and select ADD.
module alu_ctrl_dec
   import alu_pkg::*;
(
   input  logic [1:0]         aluop_i,
   input  logic [FUNCT_W-1:0] funct_i,
   output alu_sig_e           signal_o,
   output logic               illegal_o
);

   always_comb begin
      signal_o  = SIG_ADD;
      illegal_o = 1'b0;
      case (aluop_i)
         ALUOP_MEM:   signal_o = SIG_ADD;
         ALUOP_BR:    signal_o = SIG_SUB;
         ALUOP_RTYPE: begin
            case (funct_i)
               FUNCT_AND: signal_o = SIG_AND;
               FUNCT_OR:  signal_o = SIG_OR;
               FUNCT_ADD: signal_o = SIG_ADD;
               FUNCT_SUB: signal_o = SIG_SUB;
               FUNCT_SLT: signal_o = SIG_SLT;
               FUNCT_SRL: signal_o = SIG_SRL;
               default:   illegal_o = 1'b1;
            endcase
         end
         default:     illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register with stall/flush, EX-side operand forwarding and a
// saturating count of issued illegal instructions.
module alu_issue_stage
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   alu_issue_stage_if.slave  bus
);

   alu_sig_e         dec_signal;
   logic             dec_illegal;
   idex_t            idex_q, idex_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]  fwd_a, fwd_b;

   alu_ctrl_dec u_dec (
      .aluop_i   (bus.id_aluop),
      .funct_i   (bus.id_funct),
      .signal_o  (dec_signal),
      .illegal_o (dec_illegal)
   );

   // Flush beats stall; a non-valid ID slot never writes or counts as illegal.
   always_comb begin
      idex_d = idex_q;
      cnt_d  = cnt_q;
      if (bus.flush) begin
         idex_d = '0;
      end else if (!bus.stall) begin
         idex_d.valid    = bus.id_valid;
         idex_d.signal   = dec_signal;
         idex_d.shamt    = bus.id_shamt;
         idex_d.rs       = bus.id_rs;
         idex_d.rt       = bus.id_rt;
         idex_d.rd       = bus.id_rd;
         idex_d.rdata_a  = bus.id_rdataA;
         idex_d.rdata_b  = bus.id_rdataB;
         idex_d.imm      = bus.id_imm;
         idex_d.alusrc   = bus.id_alusrc;
         idex_d.regwrite = bus.id_valid & bus.id_regwrite & ~dec_illegal;
         idex_d.illegal  = bus.id_valid & dec_illegal;
         if (bus.id_valid && dec_illegal && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idex_q <= '0;
         cnt_q  <= '0;
      end else begin
         idex_q <= idex_d;
         cnt_q  <= cnt_d;
      end
   end

   assign fwd_a = fwd_sel(idex_q.rs, idex_q.rdata_a,
                          bus.exmem_regwrite, bus.exmem_rd, bus.exmem_result,
                          bus.memwb_regwrite, bus.memwb_rd, bus.memwb_result);
   assign fwd_b = fwd_sel(idex_q.rt, idex_q.rdata_b,
                          bus.exmem_regwrite, bus.exmem_rd, bus.exmem_result,
                          bus.memwb_regwrite, bus.memwb_rd, bus.memwb_result);

   assign bus.ex_valid     = idex_q.valid;
   assign bus.ex_signal    = idex_q.signal;
   assign bus.ex_shamt     = idex_q.shamt;
   assign bus.ex_dataA     = fwd_a;
   assign bus.ex_dataB     = idex_q.alusrc ? idex_q.imm : fwd_b;
   assign bus.ex_storedata = fwd_b;
   assign bus.ex_rd        = idex_q.rd;
   assign bus.ex_regwrite  = idex_q.regwrite;
   assign bus.ex_illegal   = idex_q.illegal;
   assign bus.illegal_cnt  = cnt_q;

endmodule
